// File: rtl/counter_pulse_gen.sv
// Programmable periodic pulse / terminal-count engine with shadowed configuration.
// Shadows reload only on period boundaries so register writes never glitch a period.
module counter_pulse_gen #(
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [C_DATA_WIDTH-1:0] cfg_ctrl,
    input  logic [C_DATA_WIDTH-1:0] cfg_period,
    input  logic [C_DATA_WIDTH-1:0] cfg_width,
    input  logic [C_DATA_WIDTH-1:0] cfg_burst,
    output logic [C_DATA_WIDTH-1:0] count_out,
    output logic                    pulse_out,
    output logic                    tc,
    output logic [C_DATA_WIDTH-1:0] pulse_cnt,
    output logic                    busy,
    output logic                    done
);

    localparam logic [C_DATA_WIDTH-1:0] ONE = {{(C_DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    en_d;
    logic                    en_d2;
    logic                    clr_d;
    logic                    clr_d2;
    logic                    en_rise;
    logic                    clr_rise;
    logic                    inv_s;
    logic                    inv_nx;
    logic                    active_nx;
    logic [C_DATA_WIDTH-1:0] p_s;
    logic [C_DATA_WIDTH-1:0] w_s;
    logic [C_DATA_WIDTH-1:0] n_s;
    logic [C_DATA_WIDTH-1:0] p_nx;
    logic [C_DATA_WIDTH-1:0] w_nx;
    logic [C_DATA_WIDTH-1:0] n_nx;
    logic [C_DATA_WIDTH-1:0] count_nx;
    logic [C_DATA_WIDTH-1:0] cnt_nx;
    logic [C_DATA_WIDTH-1:0] cnt_inc;
    logic                    unused_ctrl_bits;

    // A zero terminal count would make a one-cycle period with tc stuck high.
    function automatic logic [C_DATA_WIDTH-1:0] period_floor(input logic [C_DATA_WIDTH-1:0] p);
        return (p == '0) ? ONE : p;
    endfunction

    assign unused_ctrl_bits = ^cfg_ctrl[C_DATA_WIDTH-1:3];
    assign en_rise          = en_d & ~en_d2;
    assign clr_rise         = clr_d & ~clr_d2;
    assign cnt_inc          = pulse_cnt + ONE;

    always_comb begin
        state_nx  = state;
        count_nx  = count_out;
        cnt_nx    = pulse_cnt;
        p_nx      = p_s;
        w_nx      = w_s;
        n_nx      = n_s;
        inv_nx    = inv_s;
        if (clr_rise) begin
            state_nx = ST_IDLE;
            count_nx = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    count_nx = '0;
                    if (en_rise) begin
                        p_nx     = period_floor(cfg_period);
                        w_nx     = cfg_width;
                        n_nx     = cfg_burst;
                        inv_nx   = cfg_ctrl[2];
                        cnt_nx   = '0;
                        state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!cfg_ctrl[0]) begin
                        state_nx = ST_IDLE;
                        count_nx = '0;
                    end else if (count_out == p_s) begin
                        count_nx = '0;
                        cnt_nx   = cnt_inc;
                        p_nx     = period_floor(cfg_period);
                        w_nx     = cfg_width;
                        n_nx     = cfg_burst;
                        inv_nx   = cfg_ctrl[2];
                        if ((n_s != '0) && (cnt_inc == n_s)) begin
                            state_nx = ST_DONE;
                        end
                    end else begin
                        count_nx = count_out + ONE;
                    end
                end
                ST_DONE: begin
                    count_nx = '0;
                    if (!cfg_ctrl[0]) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    count_nx = '0;
                end
            endcase
        end
        active_nx = (state_nx == ST_RUN) && (count_nx < w_nx);
    end

    // Outputs are derived from next-state values so they stay cycle-aligned with count_out.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            en_d      <= 1'b0;
            en_d2     <= 1'b0;
            clr_d     <= 1'b0;
            clr_d2    <= 1'b0;
            p_s       <= '0;
            w_s       <= '0;
            n_s       <= '0;
            inv_s     <= 1'b0;
            count_out <= '0;
            pulse_cnt <= '0;
            pulse_out <= 1'b0;
            tc        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            en_d      <= cfg_ctrl[0];
            en_d2     <= en_d;
            clr_d     <= cfg_ctrl[1];
            clr_d2    <= clr_d;
            state     <= state_nx;
            p_s       <= p_nx;
            w_s       <= w_nx;
            n_s       <= n_nx;
            inv_s     <= inv_nx;
            count_out <= count_nx;
            pulse_cnt <= cnt_nx;
            pulse_out <= active_nx ^ inv_nx;
            tc        <= (state_nx == ST_RUN) && (count_nx == p_nx);
            busy      <= (state_nx == ST_RUN);
            done      <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: doc/counter_pulse_gen.md
# counter_pulse_gen

Programmable pulse/counter engine for the DRX simulator. It consumes the four 32-bit configuration registers of the counterConfig AXI4-Lite slave: control, period, width and burst. From them it generates a periodic trigger pulse train, a terminal-count strobe and status counters for downstream radar-timing logic. Configuration is shadowed and reloaded only at period boundaries, so software writes never produce glitched periods.

## Interface
- C_DATA_WIDTH, 32, width of config registers and counters
- ACLK  in  1  system clock, all logic rising-edge
- ARESET  in  1  asynchronous, active-high reset
- cfg_ctrl  in  C_DATA_WIDTH  control register: [0] enable, [1] soft_clear, [2] invert; other bits ignored
- cfg_period  in  C_DATA_WIDTH  terminal count P; period = P+1 cycles
- cfg_width  in  C_DATA_WIDTH  active pulse width W in cycles
- cfg_burst  in  C_DATA_WIDTH  pulse count N; 0 = continuous
- count_out  out  C_DATA_WIDTH  current in-period count
- pulse_out  out  1  pulse output, polarity per invert
- tc  out  1  one-cycle strobe on the last cycle of each period
- pulse_cnt  out  C_DATA_WIDTH  completed periods since start
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE. Registered edge detectors on enable and soft_clear; their previous-value flops reset to 0.
- IDLE: count_out=0, busy=0, done=0. On an enable rising edge, latch shadows P_s=max(cfg_period,1), W_s=cfg_width, N_s=cfg_burst, and invert. Clear pulse_cnt and go to RUN with count_out=0.
- RUN: count_out increments by 1 each cycle.
  - When count_out==P_s: assert tc, set count_out to 0, increment pulse_cnt (wraps at 2^C_DATA_WIDTH), and reload all shadows from the cfg_* inputs.
  - If N_s!=0 and the incremented pulse_cnt==N_s, go to DONE instead of wrapping.
- DONE: done=1, count_out=0, pulse_out at idle level, pulse_cnt held. Go to IDLE when enable is low.
- Enable low while in RUN: abort to IDLE on the next cycle. pulse_cnt is held until the next start.
- soft_clear rising edge from any state: go to IDLE and clear pulse_cnt and done. It takes priority over a simultaneous enable rising edge, which is discarded.
- pulse_out, active level: high when in RUN and count_out < W_s.
  - W_s=0: never active.
  - W_s > P_s: active for the whole period.
  - Idle level is 0, or 1 when the latched invert=1; invert XORs the output.
- Arithmetic is unsigned C_DATA_WIDTH. Compares are full width.

## Timing
- Every output is registered. Reset values: count_out=0, pulse_out=0, tc=0, pulse_cnt=0, busy=0, done=0; state=IDLE.
- ARESET clears all state immediately, without waiting for a clock.
- Start latency: enable is sampled high (rising) at edge t. At edge t+1, busy=1, count_out=0 and pulse_out is active if W_s>0.
- pulse_out, count_out and tc are cycle-aligned: tc=1 in exactly the cycle where count_out==P_s.
- A burst of N periods occupies N*(P_s+1) cycles with busy=1. done rises on the edge after the final tc.
- cfg_* changes during RUN take effect on the cycle after the next tc. The current period always completes with the old values.
- If enable is high at ARESET release, it is seen as a rising edge and RUN starts 2 cycles after release.

## Test plan
- P=4, W=2, N=3, enable rising → pulse_out pattern 1,1,0,0,0 repeated 3 times. tc at count_out=4 three times. done=1 after 15 busy cycles, pulse_cnt=3.
- N=0, P=4, W=1; write P=9 at count_out=2 → current period lasts 5 cycles, following periods 10 cycles. pulse_cnt keeps incrementing.
- W=0 → pulse_out stays 0 for the whole run. W=10 with P=4 → pulse_out=1 for the whole run. invert=1 → both waveforms complemented and idle level 1.
- Enable dropped at count_out=2 → next cycle IDLE, count_out=0, busy=0, done=0, pulse_cnt held. Re-enable → pulse_cnt restarts from 0.
- soft_clear and enable rising on the same edge → remains in IDLE, busy never asserts. soft_clear in DONE → done=0, pulse_cnt=0.
- ARESET pulsed mid-RUN with enable held high → all outputs 0 immediately. Restart occurs 2 cycles after release with count_out=0.
